sm4_round_engine: RTL and testbench

Iterative SM4 cipher core that consumes the 32 round keys produced by `key_expansion` and encrypts or decrypts one 128-bit block at one round per clock. It sits directly downstream of `key_expansion` in the SM4 datapath. It accepts a block only once key expansion reports finished, and returns the result 32 cycles after acceptance with a one-cycle valid pulse.

---
 rtl/sm4_round_engine_if.sv | 23 ++
 rtl/sm4_round_engine.sv | 104 ++++++++++
 tb/tb_sm4_round_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_round_engine_if.sv
// rtl/sm4_round_engine_if.sv - block, round-key and result signals of the SM4 round engine
interface sm4_round_engine_if;
  logic          sm4_enable_in;
  logic          key_exp_finished_in;
  logic [1023:0] rk_in;
  logic          encdec_sel_in;
  logic          data_valid_in;
  logic [127:0]  data_in;
  logic          ready_out;
  logic          busy_out;
  logic          result_valid_out;
  logic [127:0]  result_out;

  modport master (
    output sm4_enable_in, key_exp_finished_in, rk_in, encdec_sel_in, data_valid_in, data_in,
    input  ready_out, busy_out, result_valid_out, result_out
  );

  modport slave (
    input  sm4_enable_in, key_exp_finished_in, rk_in, encdec_sel_in, data_valid_in, data_in,
    output ready_out, busy_out, result_valid_out, result_out
  );
endinterface

// File: rtl/sm4_round_engine.sv
// rtl/sm4_round_engine.sv - iterative SM4 encrypt/decrypt core, one round per clock
module sm4_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  // Entry 0 sits in the top byte; indexing with ~din keeps the part-select base positive.
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign dout = SBOX[{~din, 3'b000} +: 8];
endmodule

module sm4_round_engine (
  input logic               clk,
  input logic               reset,
  sm4_round_engine_if.slave bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ROUND = 1'b1;

  logic [0:0]   state;
  logic [4:0]   rnd;
  logic [31:0]  x0, x1, x2, x3;
  logic         dec;
  logic [127:0] result;
  logic         result_valid;

  logic [4:0]   key_idx;
  logic [31:0]  k, t, b, x_new;
  logic         ready;

  // Decryption walks the same key schedule backwards; 31-rnd is ~rnd in 5 bits.
  assign key_idx = dec ? ~rnd : rnd;
  assign k       = bus.rk_in[{~key_idx, 5'b00000} +: 32];
  assign t       = x1 ^ x2 ^ x3 ^ k;

  for (genvar j = 0; j < 4; j++) begin : g_sbox
    sm4_sbox u_sbox (.din(t[8*j +: 8]), .dout(b[8*j +: 8]));
  end

  assign x_new = x0 ^ b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
               ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};

  assign ready = (state == IDLE) & bus.sm4_enable_in & bus.key_exp_finished_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rnd          <= 5'd0;
      x0           <= 32'd0;
      x1           <= 32'd0;
      x2           <= 32'd0;
      x3           <= 32'd0;
      dec          <= 1'b0;
      result       <= 128'd0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (!bus.sm4_enable_in) begin
        state <= IDLE;
        rnd   <= 5'd0;
      end else if (state == IDLE) begin
        if (bus.data_valid_in && ready) begin
          x0    <= bus.data_in[127:96];
          x1    <= bus.data_in[95:64];
          x2    <= bus.data_in[63:32];
          x3    <= bus.data_in[31:0];
          dec   <= bus.encdec_sel_in;
          rnd   <= 5'd0;
          state <= ROUND;
        end
      end else if (!bus.key_exp_finished_in) begin
        // Keys are being replaced underneath us: drop the block without a result.
        state <= IDLE;
        rnd   <= 5'd0;
      end else begin
        x0  <= x1;
        x1  <= x2;
        x2  <= x3;
        x3  <= x_new;
        rnd <= rnd + 5'd1;
        if (rnd == 5'd31) begin
          result       <= {x_new, x3, x2, x1};
          result_valid <= 1'b1;
          state        <= IDLE;
          rnd          <= 5'd0;
        end
      end
    end
  end

  assign bus.ready_out        = ready;
  assign bus.busy_out         = (state == ROUND);
  assign bus.result_valid_out = result_valid;
  assign bus.result_out       = result;
endmodule

// File: tb/tb_sm4_round_engine.sv
// tb/tb_sm4_round_engine.sv - directed self-checking bench for sm4_round_engine
module tb_sm4_round_engine;
  logic clk;
  logic reset;
  sm4_round_engine_if bus ();

  sm4_round_engine dut (.clk(clk), .reset(reset), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  int errors = 0;
  int checks = 0;
  logic [31:0]  rk [32];
  logic [127:0] last_res;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [2047:0] tbl;
    logic [31:0]   r;
    logic [7:0]    byte_in;
    tbl = SBOX;
    for (int j = 0; j < 4; j++) begin
      byte_in = a[8*j +: 8];
      r[8*j +: 8] = tbl[{~byte_in, 3'b000} +: 8];
    end
    return r;
  endfunction

  task automatic compute_keys(input logic [127:0] mk);
    logic [127:0] fk;
    logic [31:0]  k [36];
    logic [31:0]  ck, b;
    fk = 128'ha3b1bac656aa3350677d9197b27022dc;
    for (int i = 0; i < 4; i++) k[i] = mk[127-32*i -: 32] ^ fk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4*i + j) * 7) & 255);
      b = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rotl(b, 13) ^ rotl(b, 23);
      rk[i] = k[i+4];
      bus.rk_in[1023-32*i -: 32] = k[i+4];
    end
  endtask

  function automatic logic [127:0] sm4_ref(input logic [127:0] blk, input bit dec);
    logic [31:0] x [36];
    logic [31:0] b;
    for (int i = 0; i < 4; i++) x[i] = blk[127-32*i -: 32];
    for (int i = 0; i < 32; i++) begin
      b = tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[dec ? 31 - i : i]);
      x[i+4] = x[i] ^ b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic start_block(input logic [127:0] d, input logic sel);
    bus.data_in       = d;
    bus.encdec_sel_in = sel;
    bus.data_valid_in = 1'b1;
    @(posedge clk); #1;
    bus.data_valid_in = 1'b0;
  endtask

  task automatic wait_result(input int max_cyc, output int cyc, output bit got);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.result_valid_out) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sm4_enable_in = 1'b0; bus.key_exp_finished_in = 1'b0; bus.rk_in = '0;
    bus.encdec_sel_in = 1'b0; bus.data_valid_in = 1'b0; bus.data_in = '0;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_out); end
    checks++; if (bus.result_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.result_valid_out); end
    checks++; if (bus.result_out !== 128'h0) begin errors++; $display("FAIL reset_result: got %h want 0", bus.result_out); end
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.ready_out); end
    reset = 1'b0;
    compute_keys(KEY);
    bus.sm4_enable_in = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL ready_nokeys: got %b want 0", bus.ready_out); end
    bus.key_exp_finished_in = 1'b1;
    #1;
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL ready_keys: got %b want 1", bus.ready_out); end
  endtask

  task automatic test_encrypt();
    int cyc; bit got;
    start_block(PT, 1'b0);
    checks++; if (bus.busy_out !== 1'b1) begin errors++; $display("FAIL enc_busy: got %b want 1", bus.busy_out); end
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL enc_ready_busy: got %b want 0", bus.ready_out); end
    wait_result(40, cyc, got);
    checks++; if (!got || cyc != 32) begin errors++; $display("FAIL enc_latency: got %0d (seen %0d) want 32", cyc, got); end
    checks++; if (bus.result_out !== CT) begin errors++; $display("FAIL enc_result: got %h want %h", bus.result_out, CT); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL enc_busy_done: got %b want 0", bus.busy_out); end
    @(posedge clk); #1;
    checks++; if (bus.result_valid_out !== 1'b0) begin errors++; $display("FAIL enc_pulse_width: got %b want 0", bus.result_valid_out); end
    checks++; if (bus.result_out !== CT) begin errors++; $display("FAIL enc_result_hold: got %h want %h", bus.result_out, CT); end
    last_res = CT;
  endtask

  task automatic test_decrypt();
    int cyc; bit got;
    start_block(CT, 1'b1);
    wait_result(40, cyc, got);
    checks++; if (!got || cyc != 32) begin errors++; $display("FAIL dec_latency: got %0d (seen %0d) want 32", cyc, got); end
    checks++; if (bus.result_out !== PT) begin errors++; $display("FAIL dec_result: got %h want %h", bus.result_out, PT); end
    last_res = PT;
    @(posedge clk); #1;
  endtask

  task automatic test_gating();
    int cyc; bit got;
    bus.key_exp_finished_in = 1'b0;
    bus.data_in = PT2; bus.encdec_sel_in = 1'b0; bus.data_valid_in = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL gate_ready: got %b want 0", bus.ready_out); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL gate_accept: got %b want 0", bus.busy_out); end
    checks++; if (bus.result_valid_out !== 1'b0) begin errors++; $display("FAIL gate_pulse: got %b want 0", bus.result_valid_out); end
    bus.data_valid_in = 1'b0;
    bus.key_exp_finished_in = 1'b1;
    start_block(PT, 1'b0);
    bus.data_in = PT2; bus.data_valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL gate_ready_busy%0d: got %b want 0", i, bus.ready_out); end
      @(posedge clk); #1;
    end
    bus.data_valid_in = 1'b0;
    wait_result(40, cyc, got);
    checks++; if (!got || cyc + 5 != 32) begin errors++; $display("FAIL gate_latency: got %0d (seen %0d) want 32", cyc + 5, got); end
    checks++; if (bus.result_out !== CT) begin errors++; $display("FAIL gate_result: got %h want %h", bus.result_out, CT); end
    last_res = CT;
    wait_result(40, cyc, got);
    checks++; if (got) begin errors++; $display("FAIL gate_no_queue: got pulse after %0d cycles want none", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2; bit got1, got2;
    logic [127:0] exp2;
    exp2 = sm4_ref(PT2, 1'b0);
    start_block(PT, 1'b0);
    wait_result(40, cyc1, got1);
    checks++; if (bus.result_out !== CT) begin errors++; $display("FAIL b2b_result1: got %h want %h", bus.result_out, CT); end
    checks++; if (bus.ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", bus.ready_out); end
    start_block(PT2, 1'b0);
    wait_result(40, cyc2, got2);
    checks++; if (!got1 || !got2 || cyc2 + 1 != 33) begin errors++; $display("FAIL b2b_spacing: got %0d want 33", cyc2 + 1); end
    checks++; if (bus.result_out !== exp2) begin errors++; $display("FAIL b2b_result2: got %h want %h", bus.result_out, exp2); end
    last_res = exp2;
  endtask

  task automatic test_abort();
    int cyc; bit got;
    start_block(PT, 1'b0);
    repeat (15) @(posedge clk); #1;
    bus.sm4_enable_in = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL abort_idle: got %b want 0", bus.busy_out); end
    checks++; if (bus.ready_out !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b want 0", bus.ready_out); end
    bus.sm4_enable_in = 1'b1;
    wait_result(40, cyc, got);
    checks++; if (got) begin errors++; $display("FAIL abort_pulse: got pulse after %0d cycles want none", cyc); end
    checks++; if (bus.result_out !== last_res) begin errors++; $display("FAIL abort_result: got %h want %h", bus.result_out, last_res); end
    start_block(PT, 1'b1);
    repeat (31) @(posedge clk); #1;
    bus.key_exp_finished_in = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.result_valid_out !== 1'b0) begin errors++; $display("FAIL abort_final_pulse: got %b want 0", bus.result_valid_out); end
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL abort_final_idle: got %b want 0", bus.busy_out); end
    checks++; if (bus.result_out !== last_res) begin errors++; $display("FAIL abort_final_result: got %h want %h", bus.result_out, last_res); end
    bus.key_exp_finished_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int cyc; bit got;
    start_block(PT, 1'b0);
    repeat (20) @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL areset_busy: got %b want 0", bus.busy_out); end
    checks++; if (bus.result_valid_out !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", bus.result_valid_out); end
    checks++; if (bus.result_out !== 128'h0) begin errors++; $display("FAIL areset_result: got %h want 0", bus.result_out); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    start_block(PT, 1'b0);
    wait_result(40, cyc, got);
    checks++; if (!got || cyc != 32) begin errors++; $display("FAIL areset_latency: got %0d (seen %0d) want 32", cyc, got); end
    checks++; if (bus.result_out !== CT) begin errors++; $display("FAIL areset_result_run: got %h want %h", bus.result_out, CT); end
  endtask

  initial begin
    last_res = '0;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_gating();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
